// File: rtl/dual_rail_pkg.sv
// -----------------------------------------------------------------------------
// dual_rail_pkg
// Shared definitions for dual-rail (true/false rail) receive logic.
//   state_t        : deserializer FSM states (IDLE, RECV, ERROR)
//   CODE_ONE/ZERO  : legal {true, false} rail codes
//   is_valid_code  : 1 when exactly one rail is high
// No ports (package).
// -----------------------------------------------------------------------------
package dual_rail_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        ERROR
    } state_t;

    localparam logic [1:0] CODE_ONE  = 2'b10;
    localparam logic [1:0] CODE_ZERO = 2'b01;

    // 00 (spacer/stuck-low) and 11 (both rails high) are both illegal.
    function automatic logic is_valid_code(input logic t, input logic f);
        return t ^ f;
    endfunction

endpackage

// File: rtl/dual_rail_decode.sv
// -----------------------------------------------------------------------------
// dual_rail_decode
// Combinational decode of one dual-rail pair into a data bit and a valid flag.
// Ports:
//   i_rail_t  in   true rail (Q)
//   i_rail_f  in   false rail (Q-bar)
//   o_bit     out  decoded bit (meaningful only when o_valid=1)
//   o_valid   out  1 for the codes 10 (bit 1) and 01 (bit 0)
// -----------------------------------------------------------------------------
module dual_rail_decode
    import dual_rail_pkg::*;
(
    input  logic i_rail_t,
    input  logic i_rail_f,
    output logic o_bit,
    output logic o_valid
);

    logic [1:0] w_code;

    assign w_code  = {i_rail_t, i_rail_f};
    assign o_valid = is_valid_code(i_rail_t, i_rail_f);
    assign o_bit   = (w_code == CODE_ONE);

endmodule

// File: rtl/dual_rail_deserializer.sv
// -----------------------------------------------------------------------------
// dual_rail_deserializer
// Samples a dual-rail pair on SAMPLE, checks code validity and assembles WIDTH
// bits (MSB first) into DATA with a one-cycle DATA_VALID pulse.
//
// Optional feature (macro DUAL_RAIL_PARITY_EN): each frame carries one extra
// even-parity bit after the data bits; a mismatch sets sticky PAR_ERR and
// enters ERROR without updating DATA.
//
// Ports:
//   CLK         in   rising-edge clock
//   RST_n       in   asynchronous active-low reset
//   SAMPLE      in   rails evaluated only when 1
//   RAIL_T      in   true rail (Q)
//   RAIL_F      in   false rail (Q-bar)
//   CLR         in   synchronous clear of error state and partial frame
//   DATA        out  last completed frame
//   DATA_VALID  out  one-cycle pulse when DATA updates
//   CODE_ERR    out  sticky invalid-code flag
//   BUSY        out  partial frame in progress
//   PAR_ERR     out  sticky parity error (only with DUAL_RAIL_PARITY_EN)
//   BIT_CNT     out  bits accepted in the current frame
// -----------------------------------------------------------------------------
module dual_rail_deserializer
    import dual_rail_pkg::*;
#(
    parameter int WIDTH = 8,
`ifdef DUAL_RAIL_PARITY_EN
    localparam int CNT_W = $clog2(WIDTH + 2)
`else
    localparam int CNT_W = $clog2(WIDTH + 1)
`endif
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             SAMPLE,
    input  logic             RAIL_T,
    input  logic             RAIL_F,
    input  logic             CLR,
    output logic [WIDTH-1:0] DATA,
    output logic             DATA_VALID,
    output logic             CODE_ERR,
    output logic             BUSY,
`ifdef DUAL_RAIL_PARITY_EN
    output logic             PAR_ERR,
`endif
    output logic [CNT_W-1:0] BIT_CNT
);

`ifdef DUAL_RAIL_PARITY_EN
    // Holds all WIDTH data bits while the parity bit is being sampled.
    localparam int SHIFT_W    = WIDTH;
    localparam int FRAME_BITS = WIDTH + 1;
`else
    // The last data bit goes straight into DATA, so WIDTH-1 bits of history suffice.
    localparam int SHIFT_W    = WIDTH - 1;
    localparam int FRAME_BITS = WIDTH;
`endif

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BITS - 1);

    state_t             r_state;
    state_t             w_state_d;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_d;
    logic [SHIFT_W-1:0] r_shift;
    logic [SHIFT_W-1:0] w_shift_d;
    logic [WIDTH-1:0]   r_data;
    logic [WIDTH-1:0]   w_data_d;
    logic               r_valid;
    logic               w_valid_d;
`ifdef DUAL_RAIL_PARITY_EN
    logic               r_par_err;
    logic               w_par_err_d;
`endif

    logic               w_dec_bit;
    logic               w_dec_valid;
    logic [SHIFT_W:0]   w_shift_in;

    dual_rail_decode u_decode (
        .i_rail_t (RAIL_T),
        .i_rail_f (RAIL_F),
        .o_bit    (w_dec_bit),
        .o_valid  (w_dec_valid)
    );

    assign w_shift_in = {r_shift, w_dec_bit};

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
`ifdef DUAL_RAIL_PARITY_EN
            r_par_err <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_d;
            r_cnt     <= w_cnt_d;
            r_shift   <= w_shift_d;
            r_data    <= w_data_d;
            r_valid   <= w_valid_d;
`ifdef DUAL_RAIL_PARITY_EN
            r_par_err <= w_par_err_d;
`endif
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_cnt_d     = r_cnt;
        w_shift_d   = r_shift;
        w_data_d    = r_data;
        w_valid_d   = 1'b0;
`ifdef DUAL_RAIL_PARITY_EN
        w_par_err_d = r_par_err;
`endif

        if (CLR) begin
            // Clear wins over a same-cycle sample; that sample is dropped.
            w_state_d   = IDLE;
            w_cnt_d     = '0;
            w_shift_d   = '0;
`ifdef DUAL_RAIL_PARITY_EN
            w_par_err_d = 1'b0;
`endif
        end else begin
            unique case (r_state)
                IDLE, RECV: begin
                    if (SAMPLE) begin
                        if (!w_dec_valid) begin
                            w_state_d = ERROR;
                            w_cnt_d   = '0;
                            w_shift_d = '0;
                        end else if (r_cnt == LAST_CNT) begin
                            w_cnt_d   = '0;
                            w_shift_d = '0;
                            w_state_d = IDLE;
`ifdef DUAL_RAIL_PARITY_EN
                            // Even parity: XOR of data bits and parity bit must be 0.
                            if (^w_shift_in) begin
                                w_state_d   = ERROR;
                                w_par_err_d = 1'b1;
                            end else begin
                                w_data_d  = r_shift;
                                w_valid_d = 1'b1;
                            end
`else
                            w_data_d  = w_shift_in;
                            w_valid_d = 1'b1;
`endif
                        end else begin
                            w_shift_d = w_shift_in[SHIFT_W-1:0];
                            w_cnt_d   = r_cnt + CNT_W'(1);
                            w_state_d = RECV;
                        end
                    end
                end
                ERROR: begin
                    // Samples ignored; only CLR leaves this state.
                end
                default: begin
                    w_state_d = IDLE;
                end
            endcase
        end
    end

    assign DATA       = r_data;
    assign DATA_VALID = r_valid;
    assign BUSY       = (r_state == RECV);
    assign BIT_CNT    = r_cnt;
`ifdef DUAL_RAIL_PARITY_EN
    assign PAR_ERR    = r_par_err;
    // ERROR entered via parity mismatch does not count as a code error.
    assign CODE_ERR   = (r_state == ERROR) && !r_par_err;
`else
    assign CODE_ERR   = (r_state == ERROR);
`endif

endmodule

// File: tb/tb_dual_rail_deserializer.sv
// Self-checking bench for dual_rail_deserializer (WIDTH=8).
module tb_dual_rail_deserializer;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             CLK;
    logic             RST_n;
    logic             SAMPLE;
    logic             RAIL_T;
    logic             RAIL_F;
    logic             CLR;
    logic [WIDTH-1:0] DATA;
    logic             DATA_VALID;
    logic             CODE_ERR;
    logic             BUSY;
    logic [CNT_W-1:0] BIT_CNT;
`ifdef DUAL_RAIL_PARITY_EN
    logic             PAR_ERR;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int n_pulse = 0;
    logic [WIDTH-1:0] exp_q[$];

    dual_rail_deserializer #(.WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .RST_n      (RST_n),
        .SAMPLE     (SAMPLE),
        .RAIL_T     (RAIL_T),
        .RAIL_F     (RAIL_F),
        .CLR        (CLR),
        .DATA       (DATA),
        .DATA_VALID (DATA_VALID),
        .CODE_ERR   (CODE_ERR),
        .BUSY       (BUSY),
`ifdef DUAL_RAIL_PARITY_EN
        .PAR_ERR    (PAR_ERR),
`endif
        .BIT_CNT    (BIT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every DATA_VALID pulse must match the oldest expected word.
    always @(negedge CLK) begin
        if (RST_n && DATA_VALID) begin
            n_pulse++;
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'd1, 32'd0);
            end else begin
                check("sb_data", 32'(DATA), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic s, input logic t, input logic f);
        SAMPLE = s;
        RAIL_T = t;
        RAIL_F = f;
        tick();
        SAMPLE = 1'b0;
        RAIL_T = 1'($urandom_range(0, 1));
        RAIL_F = 1'($urandom_range(0, 1));
    endtask

    task automatic send_bit(input logic b);
        drive(1'b1, b, ~b);
    endtask

    task automatic gap;
        int n;
        n = $urandom_range(0, 2);
        for (int k = 0; k < n; k++) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    // Sends one frame MSB first; bad_par corrupts the parity bit when parity is enabled.
    task automatic send_frame(input logic [WIDTH-1:0] w, input bit gaps, input bit bad_par);
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (gaps && i != WIDTH - 1) gap();
`ifndef DUAL_RAIL_PARITY_EN
            if (i == 0) exp_q.push_back(w);
`endif
            send_bit(w[i]);
        end
`ifdef DUAL_RAIL_PARITY_EN
        if (gaps) gap();
        if (!bad_par) exp_q.push_back(w);
        send_bit((^w) ^ bad_par);
`else
        if (bad_par) check("bad_par_unsupported", 32'd1, 32'd0);
`endif
    endtask

    initial begin
        SAMPLE = 1'b0;
        RAIL_T = 1'b0;
        RAIL_F = 1'b0;
        CLR    = 1'b0;
        RST_n  = 1'b0;
        #12;
        check("rst_data", 32'(DATA), 32'd0);
        check("rst_valid", 32'(DATA_VALID), 32'd0);
        check("rst_code_err", 32'(CODE_ERR), 32'd0);
        check("rst_busy", 32'(BUSY), 32'd0);
        check("rst_cnt", 32'(BIT_CNT), 32'd0);
        tick();
        RST_n = 1'b1;

        // Idle with random rails: nothing moves.
        for (int k = 0; k < 10; k++) drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        check("idle_cnt", 32'(BIT_CNT), 32'd0);
        check("idle_busy", 32'(BUSY), 32'd0);
        check("idle_data", 32'(DATA), 32'd0);
        check("idle_code_err", 32'(CODE_ERR), 32'd0);

        // 0xA5, one sample per cycle, counter tracked bit by bit.
        begin
            logic [WIDTH-1:0] w;
            w = 8'hA5;
            for (int i = WIDTH - 1; i >= 0; i--) begin
                check("a5_cnt", 32'(BIT_CNT), 32'(WIDTH - 1 - i));
`ifndef DUAL_RAIL_PARITY_EN
                if (i == 0) exp_q.push_back(w);
`endif
                send_bit(w[i]);
            end
`ifdef DUAL_RAIL_PARITY_EN
            check("a5_cnt_par", 32'(BIT_CNT), 32'd8);
            exp_q.push_back(w);
            send_bit(^w);
`endif
            check("a5_valid", 32'(DATA_VALID), 32'd1);
            check("a5_data", 32'(DATA), 32'hA5);
            check("a5_cnt_end", 32'(BIT_CNT), 32'd0);
            check("a5_busy_end", 32'(BUSY), 32'd0);
            tick();
            check("a5_valid_1cyc", 32'(DATA_VALID), 32'd0);
        end

        // Back-to-back: frame 2 bit 0 sampled in the DATA_VALID cycle.
        send_frame(8'h3C, 1'b1, 1'b0);
        check("b2b_valid", 32'(DATA_VALID), 32'd1);
        send_frame(8'hFF, 1'b1, 1'b0);
        check("b2b_data", 32'(DATA), 32'hFF);
        tick();

        // Invalid code after 3 bits.
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("inv_busy_pre", 32'(BUSY), 32'd1);
        drive(1'b1, 1'b1, 1'b1);
        check("inv_code_err", 32'(CODE_ERR), 32'd1);
        check("inv_busy", 32'(BUSY), 32'd0);
        check("inv_cnt", 32'(BIT_CNT), 32'd0);
        check("inv_data", 32'(DATA), 32'hFF);
        check("inv_valid", 32'(DATA_VALID), 32'd0);
        for (int k = 0; k < 4; k++) send_bit(1'(k));
        check("err_ignore_cnt", 32'(BIT_CNT), 32'd0);
        check("err_sticky", 32'(CODE_ERR), 32'd1);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        check("clr_code_err", 32'(CODE_ERR), 32'd0);
        send_frame(8'h81, 1'b0, 1'b0);
        check("post_err_data", 32'(DATA), 32'h81);
        tick();

        // CLR together with a valid sample after 5 bits.
        for (int k = 0; k < 5; k++) send_bit(1'b1);
        check("pre_clr_cnt", 32'(BIT_CNT), 32'd5);
        CLR = 1'b1;
        send_bit(1'b1);
        CLR = 1'b0;
        check("clr_cnt", 32'(BIT_CNT), 32'd0);
        check("clr_busy", 32'(BUSY), 32'd0);
        check("clr_valid", 32'(DATA_VALID), 32'd0);
        check("clr_data", 32'(DATA), 32'h81);
        send_frame(8'h12, 1'b1, 1'b0);
        check("after_clr_data", 32'(DATA), 32'h12);
        tick();

`ifdef DUAL_RAIL_PARITY_EN
        send_frame(8'h07, 1'b0, 1'b0);
        check("par_ok_data", 32'(DATA), 32'h07);
        check("par_ok_err", 32'(PAR_ERR), 32'd0);
        tick();
        send_frame(8'h07, 1'b0, 1'b1);
        check("par_bad_err", 32'(PAR_ERR), 32'd1);
        check("par_bad_code", 32'(CODE_ERR), 32'd0);
        check("par_bad_valid", 32'(DATA_VALID), 32'd0);
        check("par_bad_data", 32'(DATA), 32'h07);
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        check("par_clr", 32'(PAR_ERR), 32'd0);
`endif

        // Asynchronous reset in the middle of a frame, mid-cycle.
        for (int k = 0; k < 3; k++) send_bit(1'b0);
        #2;
        RST_n = 1'b0;
        #1;
        check("arst_data", 32'(DATA), 32'd0);
        check("arst_cnt", 32'(BIT_CNT), 32'd0);
        check("arst_busy", 32'(BUSY), 32'd0);
        check("arst_code_err", 32'(CODE_ERR), 32'd0);
        tick();
        RST_n = 1'b1;
        send_frame(8'h5A, 1'b1, 1'b0);
        check("post_rst_data", 32'(DATA), 32'h5A);
        tick();
        tick();

        check("sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef DUAL_RAIL_PARITY_EN
        check("pulse_count", 32'(n_pulse), 32'd7);
`else
        check("pulse_count", 32'(n_pulse), 32'd6);
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
